// File: rtl/atm_req_pkg.sv
// atm_req_pkg: request-channel constants shared by the latch, encoder and consumer.
package atm_req_pkg;

    localparam int NUM_REQ       = 12;
    localparam int IDX_W         = 4;
    localparam int DEF_DB_CYCLES = 4;
    localparam int DEF_CNT_W     = 4;

    localparam logic [IDX_W-1:0] IDX_INVALID = IDX_W'(NUM_REQ);

    typedef logic [NUM_REQ-1:0] req_vec_t;

    // Indices at or above IDX_INVALID select nothing.
    function automatic req_vec_t idx_onehot(input logic [IDX_W-1:0] idx);
        return (idx < IDX_INVALID) ? req_vec_t'(1) << idx : '0;
    endfunction

endpackage

// File: rtl/req_debounce.sv
// req_debounce: one request channel; 2-flop synchroniser, optional debounce, rising-press pulse.
// COIN_REQ_DEBOUNCE_EN selects the counter-based debounce; otherwise stable follows s2 directly.
module req_debounce
`ifdef COIN_REQ_DEBOUNCE_EN
#(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 4
)
`endif
(
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);

    logic s1, s2, stable;

`ifdef COIN_REQ_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt;
    logic done;

    assign done  = (s2 != stable) && (cnt == CNT_W'(DB_CYCLES - 1));
    assign press = done && s2;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            stable <= done ? s2 : stable;
            cnt    <= (s2 == stable || done) ? '0 : cnt + 1'b1;
        end
    end
`else
    assign press = s2 & ~stable;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            stable <= s2;
        end
    end
`endif

endmodule

// File: rtl/coin_request_latch.sv
// coin_request_latch: debounced request lines into sticky pending bits, cleared by indexed ack.
// COIN_REQ_DEBOUNCE_EN enables per-channel debounce counters (DB_CYCLES/CNT_W).
module coin_request_latch
    import atm_req_pkg::*;
`ifdef COIN_REQ_DEBOUNCE_EN
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = DEF_CNT_W
)
`endif
(
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] raw_in,
    input  logic               ack,
    input  logic [IDX_W-1:0]   ack_idx,
    input  logic               clr_err,
    output logic [NUM_REQ-1:0] pending,
    output logic               any_pending,
    output logic               lost,
    output logic               ack_err
);

    req_vec_t press, ack_sel, pending_nx;
    logic ack_ok, lost_set;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_ch
`ifdef COIN_REQ_DEBOUNCE_EN
        req_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
            .clock(clock), .reset(reset), .raw(raw_in[k]), .press(press[k])
        );
`else
        req_debounce u_db (
            .clock(clock), .reset(reset), .raw(raw_in[k]), .press(press[k])
        );
`endif
    end

    // A press in the same cycle as its own ack re-arms the bit and is not a loss.
    always_comb begin
        ack_sel    = ack ? idx_onehot(ack_idx) : '0;
        ack_ok     = |(ack_sel & pending);
        pending_nx = (pending & ~ack_sel) | press;
        lost_set   = |(press & pending & ~ack_sel);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending     <= '0;
            any_pending <= 1'b0;
            lost        <= 1'b0;
            ack_err     <= 1'b0;
        end else begin
            pending     <= pending_nx;
            any_pending <= |pending_nx;
            lost        <= lost_set | (lost & ~clr_err);
            ack_err     <= (ack & ~ack_ok) | (ack_err & ~clr_err);
        end
    end

endmodule

// File: doc/coin_request_latch.md
# coin_request_latch

Captures the machine's 12 raw active-high request lines (coin sensors, keypad, service buttons), synchronises and debounces each one, and turns every clean press into a sticky pending bit. The 12-bit `pending` vector feeds the downstream 12→4 priority encoder. The consumer returns the encoded index on `ack`/`ack_idx`, which clears exactly that bit. Sits between the board I/O pins and the request encoder in the processor front end.

## Interface
- `NUM_REQ`, 12, number of request channels (fixed at 12 for the encoder; other values unsupported)
- `IDX_W`, 4, width of `ack_idx`
- `DB_CYCLES`, 4, consecutive stable cycles needed to accept a level change (1..15)
- `CNT_W`, 4, debounce counter width (must hold `DB_CYCLES-1`)

Ports:
- `clock` in 1: single clock; all logic on its rising edge
- `reset` in 1: synchronous, active-high
- `raw_in` in 12: asynchronous request lines, active-high
- `ack` in 1: consumer has serviced one request this cycle
- `ack_idx` in 4: index being acknowledged (encoder output code)
- `clr_err` in 1: clears `lost` and `ack_err`
- `pending` out 12: registered pending-request vector, to encoder input
- `any_pending` out 1: registered OR of `pending`
- `lost` out 1: sticky; a press arrived on a channel already pending
- `ack_err` out 1: sticky; `ack` with `ack_idx` ≥ 12 or with the indexed bit clear

## Operation
- Per channel k: 2-flop synchroniser `s1→s2`, debounced level `stable[k]`, counter `cnt[k]`.
- Debounce, each edge: if `s2==stable`, `cnt<=0`. Otherwise, if `cnt==DB_CYCLES-1`, set `stable<=s2` and `cnt<=0`; else `cnt<=cnt+1`. Any bounce back to `stable` restarts the count.
- Press event `press[k]`: combinational, asserted in the cycle where `stable[k]` is about to go 0→1. Falling transitions generate no event.
- Pending update per bit, each edge:
  - `press[k]` → `pending[k]<=1`.
  - else `ack && ack_idx==k` → `pending[k]<=0`.
  - else hold.
- Simultaneous `press[k]` and ack of k: pending stays 1; `lost` is not set. The new press replaces the serviced one.
- `press[k]` while `pending[k]==1` and no ack of k that cycle: `lost<=1`. The press is merged and not queued.
- Invalid ack (`ack_idx`≥12, or `pending[ack_idx]==0`): no pending change; `ack_err<=1`.
- `clr_err` clears `lost`/`ack_err`. A set condition in the same cycle wins: the flag stays 1.
- Multiple channels may press in the same cycle; all of them are captured.

## Timing
- Reset: `pending`=0, `any_pending`=0, `lost`=0, `ack_err`=0; `s1`, `s2`, `stable`, `cnt` all 0.
- A line held high through reset counts as a new press after the release latency.
- Latency, raw rise (held clean) to `pending[k]`=1: 2+`DB_CYCLES` edges. The default is 6.
- Ack to bit cleared: 1 edge; `pending[k]` reads 0 in the following cycle.
- `any_pending` tracks `pending` in the same cycle. It is computed from the next-state value and registered.
- Pulses shorter than `DB_CYCLES` cycles after synchronisation are rejected.
- Reset asserted mid-debounce or mid-pending discards all in-flight state. No event is emitted on reset release unless the line is high.

## Configuration
- `COIN_REQ_DEBOUNCE_EN` defined: debounce counters present, behaviour as above.
- Not defined: counters removed; `stable<=s2` every edge and `press = s2 & ~stable`. Latency becomes 3 edges and every synchronised glitch counts as a press. `DB_CYCLES`/`CNT_W` are ignored.

## Structure
- Shared package `atm_req_pkg`: `NUM_REQ`=12, `IDX_W`=4, default `DB_CYCLES`, and the localparam for an invalid index (≥12). The same package is used by the encoder and consumer.
- One sub-module `req_debounce` handles a single channel: synchroniser, counter, `stable`, `press` output. It is instantiated 12 times.
- Pending/ack/error logic lives in the top level.

## Test plan
- Reset, then `raw_in[5]` held high → `pending`=12'h020 and `any_pending`=1 exactly 6 edges later; ack with idx 5 → `pending`=0 next cycle.
- `raw_in[3]` glitches high for 3 cycles, then low → `pending` stays 0. The same line held for 4 cycles after sync → bit 3 set.
- `raw_in[11]` and `raw_in[0]` rise in the same cycle → `pending`=12'h801; ack 11 → 12'h001; ack 0 → 0; `lost`=0 throughout.
- Channel 7 pending; release and re-press so the press lands in the ack-7 cycle → `pending[7]` stays 1, `lost`=0. A second re-press without ack → `lost`=1; `clr_err` → 0.
- Ack with `ack_idx`=13, then ack idx 2 with bit 2 clear → `pending` unchanged, `ack_err`=1.
- `reset` asserted 3 cycles into a debounce on channel 9 with the line still high → all outputs 0 during reset. `pending[9]` sets 6 edges after reset release. Without `COIN_REQ_DEBOUNCE_EN`, the same stimulus gives 3 edges.
